// File: rtl/simd_argmax_unit.sv
// Streaming signed argmax/argmin reduction: consumes one element per cycle and
// reports the best value, its position and the frame length once per frame.
module simd_argmax_unit #(
    parameter int unsigned FUNCTION_BITS = 4,
    parameter int unsigned BIT_WIDTH     = 32,
    parameter int unsigned INDEX_BITS    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FUNCTION_BITS-1:0]      fn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [BIT_WIDTH-1:0]   in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BIT_WIDTH-1:0]          out_value,
    output logic [INDEX_BITS-1:0]         out_index,
    output logic [INDEX_BITS-1:0]         out_count,
    output logic                          out_err
);

    localparam logic [FUNCTION_BITS-1:0] FN_ARGMAX = FUNCTION_BITS'(0);
    localparam logic [FUNCTION_BITS-1:0] FN_ARGMIN = FUNCTION_BITS'(1);
    localparam logic [INDEX_BITS-1:0]    CNT_MAX   = '1;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

    state_e                       state_q, state_d;
    logic [FUNCTION_BITS-1:0]     fn_q, fn_d;
    logic [INDEX_BITS-1:0]        count_q, count_d;
    logic signed [BIT_WIDTH-1:0]  best_value_q, best_value_d;
    logic [INDEX_BITS-1:0]        best_index_q, best_index_d;
    logic [BIT_WIDTH-1:0]         out_value_q, out_value_d;
    logic [INDEX_BITS-1:0]        out_index_q, out_index_d;
    logic [INDEX_BITS-1:0]        out_count_q, out_count_d;
    logic                         out_err_q, out_err_d;

    logic                         frame_start;
    logic [FUNCTION_BITS-1:0]     frame_fn;
    logic                         fn_ok;
    logic                         better;

    // The first element's fn governs the whole frame, including that element itself.
    always_comb begin
        frame_start = (count_q == '0);
        frame_fn    = frame_start ? fn : fn_q;
        fn_ok       = (frame_fn == FN_ARGMAX) || (frame_fn == FN_ARGMIN);
        better      = 1'b0;
        if (frame_fn == FN_ARGMAX) begin
            better = (in_data > best_value_q);
        end else if (frame_fn == FN_ARGMIN) begin
            better = (in_data < best_value_q);
        end
    end

    // Next-state and result-load logic.
    always_comb begin
        state_d      = state_q;
        fn_d         = fn_q;
        count_d      = count_q;
        best_value_d = best_value_q;
        best_index_d = best_index_q;
        out_value_d  = out_value_q;
        out_index_d  = out_index_q;
        out_count_d  = out_count_q;
        out_err_d    = out_err_q;

        unique case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    if (frame_start) begin
                        fn_d         = fn;
                        best_value_d = in_data;
                        best_index_d = '0;
                        count_d      = INDEX_BITS'(1);
                    end else begin
                        // Strict compare keeps the earliest index on ties; the
                        // saturated count doubles as the clamped replacement index.
                        if (better) begin
                            best_value_d = in_data;
                            best_index_d = count_q;
                        end
                        if (count_q != CNT_MAX) begin
                            count_d = count_q + INDEX_BITS'(1);
                        end
                    end
                    if (in_last) begin
                        state_d     = DONE;
                        out_value_d = fn_ok ? best_value_d : '0;
                        out_index_d = fn_ok ? best_index_d : '0;
                        out_count_d = count_d;
                        out_err_d   = !fn_ok;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    count_d = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ACCUM;
            fn_q         <= '0;
            count_q      <= '0;
            best_value_q <= '0;
            best_index_q <= '0;
            out_value_q  <= '0;
            out_index_q  <= '0;
            out_count_q  <= '0;
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fn_q         <= fn_d;
            count_q      <= count_d;
            best_value_q <= best_value_d;
            best_index_q <= best_index_d;
            out_value_q  <= out_value_d;
            out_index_q  <= out_index_d;
            out_count_q  <= out_count_d;
            out_err_q    <= out_err_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out_value = out_value_q;
    assign out_index = out_index_q;
    assign out_count = out_count_q;
    assign out_err   = out_err_q;

endmodule
